// File: rtl/sdr_pkg.sv
// Shared types and widths for the SDR user-port arbiter.
// Imported by the arbiter top and its round-robin picker.
package sdr_pkg;

  localparam int SDR_DW = 16;
  localparam int SDR_AW = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WDATA,
    RDATA,
    DONE
  } arb_state_t;

endpackage

// File: rtl/sdr_rr_picker.sv
// Combinational round-robin search: first set request at or after ptr.
// Produces a one-hot grant, its index, and an any-request flag.
module sdr_rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  function automatic logic [IW-1:0] slot(
    input logic [IW-1:0] p,
    input int            k
  );
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan backwards so the nearest slot to ptr is the last writer.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = |req;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[slot(ptr, k)]) begin
        gnt = '0;
        gnt[slot(ptr, k)] = 1'b1;
        idx = slot(ptr, k);
      end
    end
  end

endmodule

// File: rtl/sdr_req_arbiter.sv
// Round-robin arbiter sharing the sdr_top user port among NUM_REQ clients.
// One burst at a time: issue pulse, BURST_LEN beats, done or timeout.
module sdr_req_arbiter
  import sdr_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int BURST_LEN   = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [SDR_AW*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [SDR_DW*NUM_REQ-1:0] wdata,
  output logic [NUM_REQ-1:0]        wdata_pop,
  output logic [SDR_DW-1:0]         rd_data,
  output logic [NUM_REQ-1:0]        rd_vld,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic                      sdr_wr_req,
  output logic [SDR_AW-1:0]         sdr_waddr,
  output logic [SDR_DW-1:0]         sdr_wdata_in,
  output logic                      sdr_wr_vld,
  input  logic                      sdr_wr_ready,
  output logic                      sdr_rd_req,
  output logic [SDR_AW-1:0]         sdr_raddr,
  input  logic [SDR_DW-1:0]         sdr_rdata_out,
  input  logic                      sdr_rd_vld
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  arb_state_t         state;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] own_oh;
  logic               we_q;
  logic [SDR_AW-1:0]  addr_q;
  logic [BW-1:0]      beat;
  logic [TW-1:0]      tmo;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [SDR_AW-1:0]  pick_addr;
  logic [SDR_DW-1:0]  own_wdata;
  logic [IW-1:0]      next_ptr;
  logic               beat_ok;
  logic               last_beat;
  logic               tmo_hit;

  sdr_rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    pick_addr = '0;
    own_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i])
        pick_addr = req_addr[i*SDR_AW +: SDR_AW];
      if (IW'(i) == owner)
        own_wdata = wdata[i*SDR_DW +: SDR_DW];
    end
  end

  assign next_ptr = (owner == IW'(NUM_REQ - 1)) ?
                    '0 : owner + 1'b1;

  assign beat_ok   = (state == WDATA && sdr_wr_ready) ||
                     (state == RDATA && sdr_rd_vld);
  assign last_beat = beat_ok && (beat == BW'(BURST_LEN - 1));
  assign tmo_hit   = tmo == TW'(TIMEOUT_CYC - 1);

  assign sdr_wr_vld   = state == WDATA;
  assign sdr_wdata_in = sdr_wr_vld ? own_wdata : '0;
  assign wdata_pop    = (sdr_wr_vld && sdr_wr_ready) ? own_oh : '0;
  assign rd_data      = (state == RDATA) ? sdr_rdata_out : '0;
  assign rd_vld       = (state == RDATA && sdr_rd_vld) ? own_oh : '0;
  assign sdr_waddr    = we_q ? addr_q : '0;
  assign sdr_raddr    = we_q ? '0 : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      own_oh     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      beat       <= '0;
      tmo        <= '0;
      req_ready  <= '0;
      done       <= '0;
      err        <= 1'b0;
      sdr_wr_req <= 1'b0;
      sdr_rd_req <= 1'b0;
    end else begin
      req_ready  <= '0;
      done       <= '0;
      sdr_wr_req <= 1'b0;
      sdr_rd_req <= 1'b0;
      // Read data with no read in flight is dropped and flagged.
      err        <= sdr_rd_vld && (state != RDATA);
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            state      <= ISSUE;
            owner      <= pick_idx;
            own_oh     <= pick_gnt;
            we_q       <= |(req_we & pick_gnt);
            addr_q     <= pick_addr;
            req_ready  <= pick_gnt;
            sdr_wr_req <= |(req_we & pick_gnt);
            sdr_rd_req <= ~|(req_we & pick_gnt);
          end
        end
        ISSUE: begin
          state <= we_q ? WDATA : RDATA;
          beat  <= '0;
          tmo   <= '0;
        end
        WDATA, RDATA: begin
          tmo <= tmo + 1'b1;
          if (beat_ok) beat <= beat + 1'b1;
          if (last_beat) begin
            state  <= DONE;
            done   <= own_oh;
            rr_ptr <= next_ptr;
          end else if (tmo_hit) begin
            state  <= IDLE;
            err    <= 1'b1;
            rr_ptr <= next_ptr;
            we_q   <= 1'b0;
            addr_q <= '0;
          end
        end
        DONE: begin
          state  <= IDLE;
          we_q   <= 1'b0;
          addr_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_req_arbiter.sv
// Scoreboard bench for sdr_req_arbiter with a behavioural sdr_top stand-in.
// Clients push expected bursts; a negedge monitor pops and compares.
module tb_sdr_req_arbiter;

  localparam int N   = 3;
  localparam int BL  = 8;
  localparam int TMO = 64;

  typedef struct packed {
    logic              we;
    logic [31:0]       addr;
    logic [BL-1:0][15:0] w;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_we, req_ready;
  logic [N-1:0]    wdata_pop, rd_vld, done;
  logic [32*N-1:0] req_addr;
  logic [16*N-1:0] wdata;
  logic [31:0]     addr_a [N];
  logic [15:0]     wd_a   [N];
  logic [15:0]     rd_data;
  logic            err;
  logic            sdr_wr_req, sdr_wr_vld, sdr_wr_ready;
  logic            sdr_rd_req, sdr_rd_vld;
  logic [31:0]     sdr_waddr, sdr_raddr;
  logic [15:0]     sdr_wdata_in, sdr_rdata_out;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_addr[32*g +: 32] = addr_a[g];
    assign wdata[16*g +: 16]    = wd_a[g];
  end

  sdr_req_arbiter #(
    .NUM_REQ     (N),
    .BURST_LEN   (BL),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .wdata         (wdata),
    .wdata_pop     (wdata_pop),
    .rd_data       (rd_data),
    .rd_vld        (rd_vld),
    .done          (done),
    .err           (err),
    .sdr_wr_req    (sdr_wr_req),
    .sdr_waddr     (sdr_waddr),
    .sdr_wdata_in  (sdr_wdata_in),
    .sdr_wr_vld    (sdr_wr_vld),
    .sdr_wr_ready  (sdr_wr_ready),
    .sdr_rd_req    (sdr_rd_req),
    .sdr_raddr     (sdr_raddr),
    .sdr_rdata_out (sdr_rdata_out),
    .sdr_rd_vld    (sdr_rd_vld)
  );

  int   vecs = 0;
  int   miscompares = 0;
  txn_t exp_q [N][$];
  logic [15:0] ref_mem [int];
  logic [15:0] mem [int];

  bit rd_block = 0;
  bit stray_inj = 0;
  int stall_n = 0;
  bit exp_tmo = 0;
  bit exp_stray = 0;
  int tmo_seen = 0;
  int stray_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_word(input int a);
    return 16'(a) * 16'h03b1 ^ 16'h5a5a;
  endfunction

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [15:0] mem_rd(input int a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic int rr_pick(input logic [N-1:0] rv, input int p);
    for (int k = 0; k < N; k++)
      if (rv[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    return (g < 0) ? '0 : N'(1) << g;
  endfunction

  function automatic logic any_out();
    return |{req_ready, wdata_pop, rd_vld, done, err, sdr_wr_req,
             sdr_rd_req, sdr_wr_vld, rd_data, sdr_waddr, sdr_raddr,
             sdr_wdata_in};
  endfunction

  // Behavioural sdr_top: memory, random wr_ready, random read latency.
  initial begin
    int w_addr, w_idx, r_addr, r_idx, r_left;
    w_addr = 0; w_idx = 0; r_addr = 0; r_idx = 0; r_left = 0;
    sdr_wr_ready = 1'b0;
    sdr_rd_vld = 1'b0;
    sdr_rdata_out = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        r_left = 0;
        w_idx = 0;
      end else begin
        if (sdr_wr_req) begin
          w_addr = int'(sdr_waddr);
          w_idx = 0;
        end
        if (sdr_wr_vld && sdr_wr_ready) begin
          mem[w_addr + w_idx] = sdr_wdata_in;
          w_idx++;
        end
        if (sdr_rd_vld && r_left > 0) begin
          r_idx++;
          r_left--;
        end
        if (sdr_rd_req) begin
          r_addr = int'(sdr_raddr);
          r_idx = 0;
          r_left = BL;
        end
        if (err) r_left = 0;
      end
      @(posedge clk);
      #1;
      if (stall_n > 0) begin
        sdr_wr_ready = 1'b0;
        stall_n--;
      end else begin
        sdr_wr_ready = ($urandom_range(0, 3) != 0);
      end
      if (stray_inj) begin
        sdr_rd_vld = 1'b1;
        sdr_rdata_out = 16'hdead;
        stray_inj = 0;
      end else if (r_left > 0 && !rd_block && $urandom_range(0, 2) != 0) begin
        sdr_rd_vld = 1'b1;
        sdr_rdata_out = mem_rd(r_addr + r_idx);
      end else begin
        sdr_rd_vld = 1'b0;
        sdr_rdata_out = 16'($urandom);
      end
    end
  end

  // Monitor: grant order from the round-robin rule, beats from the scoreboard.
  initial begin
    int cyc, issue_cyc, owner_m, beat_m, ptr_m, g, o;
    bit active;
    txn_t cur;
    logic [N-1:0] prev_rv;
    cyc = 0; issue_cyc = 0; owner_m = 0; beat_m = 0; ptr_m = 0;
    active = 0; cur = '0; prev_rv = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        ptr_m = 0;
        active = 0;
        for (int i = 0; i < N; i++) exp_q[i].delete();
      end else begin
        if (req_ready != '0) begin
          g = rr_pick(prev_rv, ptr_m);
          chk("grant", req_ready, onehot(g));
          o = -1;
          for (int i = 0; i < N; i++) if (req_ready[i]) o = i;
          chk("pending_txns", (o >= 0) ? exp_q[o].size() : 0, 1);
          if (o >= 0 && exp_q[o].size() > 0) begin
            cur = exp_q[o].pop_front();
            owner_m = o;
            active = 1;
            beat_m = 0;
            issue_cyc = cyc;
            chk("wr_req", sdr_wr_req, cur.we);
            chk("rd_req", sdr_rd_req, !cur.we);
            chk("issue_addr", cur.we ? sdr_waddr : sdr_raddr, cur.addr);
          end
        end else if (sdr_wr_req || sdr_rd_req) begin
          chk("req_without_grant", {sdr_wr_req, sdr_rd_req}, 0);
        end
        if (wdata_pop != '0 || (sdr_wr_vld && sdr_wr_ready)) begin
          chk("pop_vec", wdata_pop,
              (active && cur.we) ? onehot(owner_m) : '0);
          chk("pop_needs_ready", sdr_wr_ready, 1);
          chk("wbeat_in_burst", beat_m < BL, 1);
          if (beat_m < BL) chk("wdata", sdr_wdata_in, cur.w[beat_m]);
          beat_m++;
        end
        if (rd_vld != '0 || (sdr_rd_vld && active && !cur.we)) begin
          chk("rd_vld_vec", rd_vld,
              (active && !cur.we) ? onehot(owner_m) : '0);
          chk("rbeat_in_burst", beat_m < BL, 1);
          if (beat_m < BL) chk("rd_data", rd_data, cur.w[beat_m]);
          beat_m++;
        end
        if (done != '0) begin
          chk("done_vec", done, active ? onehot(owner_m) : '0);
          chk("done_beats", beat_m, BL);
          ptr_m = (owner_m + 1) % N;
          active = 0;
        end
        if (err) begin
          if (exp_tmo && active) begin
            // RDATA lasts TMO cycles after the ISSUE cycle; err follows.
            chk("tmo_latency", cyc - issue_cyc, TMO + 1);
            chk("tmo_beats", beat_m, 0);
            chk("tmo_no_done", done, 0);
            ptr_m = (owner_m + 1) % N;
            active = 0;
            exp_tmo = 0;
            tmo_seen++;
          end else if (exp_stray && !active) begin
            exp_stray = 0;
            stray_seen++;
          end else begin
            chk("unexpected_err", err, 0);
          end
        end
      end
      prev_rv = req_valid;
    end
  end

  task automatic run_txn(input int i, input bit we,
                         input logic [31:0] a, input bit fixed);
    txn_t t;
    int k, n;
    bit got, fin, rdy, pop;
    @(posedge clk);
    #1;
    t.we = we;
    t.addr = a;
    for (int b = 0; b < BL; b++) begin
      if (we) begin
        t.w[b] = fixed ? 16'h1000 + 16'(b) : 16'($urandom);
        ref_mem[int'(a) + b] = t.w[b];
      end else begin
        t.w[b] = ref_rd(int'(a) + b);
      end
    end
    exp_q[i].push_back(t);
    req_we[i] = we;
    addr_a[i] = a;
    wd_a[i] = we ? t.w[0] : 16'h0;
    req_valid[i] = 1'b1;
    k = 0; n = 0; got = 0; fin = 0;
    while (!fin && n < 3000) begin
      @(negedge clk);
      n++;
      rdy = req_ready[i];
      pop = wdata_pop[i];
      if (got && (done[i] || err)) fin = 1;
      @(posedge clk);
      #1;
      if (rdy) begin
        req_valid[i] = 1'b0;
        got = 1;
      end
      if (pop) begin
        k++;
        if (k < BL) wd_a[i] = t.w[k];
      end
    end
    chk("txn_complete", fin, 1);
    req_valid[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, miscompares %0d", miscompares);
    $fatal(1);
  end

  initial begin
    int p, n;
    txn_t t;
    req_valid = '0;
    req_we = '0;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = '0;
      wd_a[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: nothing moves for 10 us.
    repeat (1000) begin
      @(negedge clk);
      chk("idle_outputs", any_out(), 0);
    end

    // Client 0 writes a ramp, client 1 reads it back.
    run_txn(0, 1'b1, 32'h0, 1'b1);
    run_txn(1, 1'b0, 32'h0, 1'b0);

    // Simultaneous requests rotate through the clients.
    repeat (2) begin
      fork
        run_txn(0, 1'b1, 32'h8, 1'b0);
        run_txn(1, 1'b0, 32'h8, 1'b0);
      join
    end

    // Independent random traffic, one region per client.
    for (int i = 0; i < N; i++) begin
      fork
        automatic int c = i;
        begin
          repeat (10) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            run_txn(c, 1'($urandom_range(0, 1)),
                    32'(c * 'h100 + 8 * $urandom_range(0, 3)), 1'b0);
          end
        end
      join_none
    end
    wait fork;

    // wr_ready held low mid-burst.
    fork
      run_txn(0, 1'b1, 32'h10, 1'b0);
      begin
        p = 0; n = 0;
        while (p < 3 && n < 500) begin
          @(negedge clk);
          n++;
          if (wdata_pop[0]) p++;
        end
        stall_n = 5;
        repeat (5) begin
          @(negedge clk);
          chk("stall_no_pop", wdata_pop, 0);
        end
      end
    join

    // Read data never arrives: timeout, then the next client is served.
    exp_tmo = 1;
    rd_block = 1;
    fork
      run_txn(0, 1'b0, 32'h20, 1'b0);
      begin
        repeat (5) @(posedge clk);
        run_txn(1, 1'b1, 32'h120, 1'b0);
      end
    join
    rd_block = 0;
    chk("tmo_seen", tmo_seen, 1);

    // Read data with no read outstanding.
    repeat (4) @(negedge clk);
    exp_stray = 1;
    stray_inj = 1;
    repeat (4) @(negedge clk);
    chk("stray_seen", stray_seen, 1);

    // Reset during write beat 3, then a clean write/read.
    t.we = 1'b1;
    t.addr = 32'h40;
    t.w = {BL{16'hbeef}};
    exp_q[0].push_back(t);
    @(posedge clk);
    #1;
    req_we[0] = 1'b1;
    addr_a[0] = 32'h40;
    wd_a[0] = 16'hbeef;
    req_valid[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[0] && n < 100);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    p = 0; n = 0;
    while (p < 3 && n < 500) begin
      @(negedge clk);
      n++;
      if (wdata_pop[0]) p++;
    end
    chk("rst_reached_beat3", p, 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", any_out(), 0);
    wd_a[0] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_txn(0, 1'b1, 32'h40, 1'b0);
    run_txn(0, 1'b0, 32'h40, 1'b0);

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
